// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// on contention the port that was not granted last wins.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic  req_a_i,
    input  logic  req_b_i,
    input  port_e last_gnt_i,
    output port_e winner_o,
    output logic  valid_o
);

    always_comb begin
        winner_o = PORT_A;
        if (req_a_i && req_b_i) begin
            winner_o = (last_gnt_i == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b_i) begin
            winner_o = PORT_B;
        end
    end

    assign valid_o = req_a_i | req_b_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read single-port memory between requesters A and B,
// one access at a time: IDLE (arbitrate) -> ACCESS (gnt + strobe) -> RESP (done).
//
// Handshake: a requester holds req_x with stable we_x/addr_x/wdata_x until it
// sees gnt_x; fields are captured in the IDLE cycle that produces the grant,
// and done_x pulses exactly one cycle after gnt_x.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [1:0]        state_dbg
);

    state_e            state_q, state_d;
    port_e             owner_q, owner_d;
    port_e             last_gnt_q, last_gnt_d;
    port_e             winner;
    logic              pick_valid;
    logic              we_q, we_d;
    logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic              done_a_q, done_a_d, done_b_q, done_b_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter_2 u_rr (
        .req_a_i    (req_a),
        .req_b_i    (req_b),
        .last_gnt_i (last_gnt_q),
        .winner_o   (winner),
        .valid_o    (pick_valid)
    );

    assign sel_we    = (winner == PORT_A) ? we_a    : we_b;
    assign sel_addr  = (winner == PORT_A) ? addr_a  : addr_b;
    assign sel_wdata = (winner == PORT_A) ? wdata_a : wdata_b;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ACCESS;
                    owner_d     = winner;
                    last_gnt_d  = winner;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    // data_in only moves for writes so reads never toggle it
                    if (sel_we) din_d = sel_wdata;
                    gnt_a_d     = (winner == PORT_A);
                    gnt_b_d     = (winner == PORT_B);
                    mem_read_d  = !sel_we;
                    mem_write_d = sel_we;
                end
            end
            ACCESS: begin
                state_d  = RESP;
                done_a_d = (owner_q == PORT_A);
                done_b_d = (owner_q == PORT_B);
            end
            RESP: begin
                state_d = IDLE;
                if (!we_q) begin
                    if (owner_q == PORT_A) rdata_a_d = mem_data_out;
                    else                   rdata_b_d = mem_data_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= PORT_A;
            last_gnt_q  <= PORT_B;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // The memory's own output register lands during RESP, so read data is
    // forwarded from it in that cycle and held in rdata_x_q afterwards.
    assign rdata_a = (state_q == RESP && owner_q == PORT_A && !we_q) ? mem_data_out : rdata_a_q;
    assign rdata_b = (state_q == RESP && owner_q == PORT_B && !we_q) ? mem_data_out : rdata_b_q;

    assign gnt_a       = gnt_a_q;
    assign gnt_b       = gnt_b_q;
    assign done_a      = done_a_q;
    assign done_b      = done_b_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_data_in = din_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter wrapped around a 256x16 registered-read memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, gnt_b, done_a, done_b, mem_read, mem_write;
    logic [15:0] rdata_a, rdata_b, mem_data_in, mem_data_out;
    logic [7:0]  mem_address;
    logic [1:0]  state_dbg;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .state_dbg(state_dbg)
    );

    // Memory model, preloaded on the first edge (mem[0x10] = 0x1234).
    logic [15:0] mem [256];
    logic        preload_done = 1'b0;
    always @(posedge clock) begin
        if (!preload_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 16'h1234 : 16'h0000;
            preload_done <= 1'b1;
        end else begin
            if (mem_write) mem[mem_address] <= mem_data_in;
            if (mem_read)  mem_data_out <= mem[mem_address];
        end
    end

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          min_cyc;
    } txn_t;

    // Expected outputs for one future cycle.
    typedef struct {
        logic [5:0]  strb;      // {gnt_a, gnt_b, done_a, done_b, mem_read, mem_write}
        logic [1:0]  st;
        logic        upd_addr;
        logic [7:0]  addr;
        logic        upd_din;
        logic [15:0] din;
        logic        done_rd;
    } slot_t;

    txn_t        q_a[$], q_b[$];
    slot_t       ring[4];
    logic [15:0] ref_mem[256];
    logic [15:0] exp_q_a[$], exp_q_b[$];
    logic [15:0] last_rd_a, last_rd_b, exp_din;
    logic [7:0]  exp_addr;
    int          cyc = 0, next_decide = 0;
    port_e       last_gnt_m;
    int          n_vec = 0, n_err = 0;
    logic        arm_rst30 = 1'b0;
    int          gnt_cyc[$];
    logic        gnt_port[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s.strb = '0; s.st = IDLE; s.upd_addr = 1'b0; s.addr = '0;
        s.upd_din = 1'b0; s.din = '0; s.done_rd = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ring[i] = empty_slot();
        next_decide = cyc;
        last_gnt_m  = PORT_B;
        exp_addr    = '0;
        exp_din     = '0;
        last_rd_a   = '0;
        last_rd_b   = '0;
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    // Arbitration decision for an arbiter that is free this cycle.
    task automatic decide();
        logic pick_b, we;
        logic [7:0] ad;
        logic [15:0] wd;
        slot_t g, d;
        if (!req_a && !req_b) return;
        pick_b     = (req_a && req_b) ? (last_gnt_m == PORT_A) : req_b;
        we         = pick_b ? we_b : we_a;
        ad         = pick_b ? addr_b : addr_a;
        wd         = pick_b ? wdata_b : wdata_a;
        last_gnt_m = pick_b ? PORT_B : PORT_A;
        g = empty_slot();
        g.strb = {~pick_b, pick_b, 2'b00, ~we, we};
        g.st = ACCESS; g.upd_addr = 1'b1; g.addr = ad; g.upd_din = we; g.din = wd;
        d = empty_slot();
        d.strb = {2'b00, ~pick_b, pick_b, 2'b00};
        d.st = RESP; d.done_rd = !we;
        if (we) ref_mem[ad] = wd;
        else if (pick_b) exp_q_b.push_back(ref_mem[ad]);
        else exp_q_a.push_back(ref_mem[ad]);
        ring[(cyc + 1) % 4] = g;
        ring[(cyc + 2) % 4] = d;
        next_decide = cyc + 3;
    endtask

    task automatic cycle(input logic rst);
        slot_t s;
        txn_t  t;
        @(posedge clock); #1;
        cyc++;
        if (reset) model_reset();
        s = ring[cyc % 4];
        if (s.upd_addr) exp_addr = s.addr;
        if (s.upd_din)  exp_din = s.din;
        check("strobes", {gnt_a, gnt_b, done_a, done_b, mem_read, mem_write}, s.strb);
        check("state", state_dbg, s.st);
        check("mem_address", mem_address, exp_addr);
        check("mem_data_in", mem_data_in, exp_din);
        if (s.strb[3]) begin
            if (s.done_rd && exp_q_a.size() > 0) last_rd_a = exp_q_a.pop_front();
            check("rdata_a", rdata_a, last_rd_a);
        end
        if (s.strb[2]) begin
            if (s.done_rd && exp_q_b.size() > 0) last_rd_b = exp_q_b.pop_front();
            check("rdata_b", rdata_b, last_rd_b);
        end
        if (gnt_a) begin gnt_cyc.push_back(cyc); gnt_port.push_back(1'b0); end
        if (gnt_b) begin gnt_cyc.push_back(cyc); gnt_port.push_back(1'b1); end
        ring[cyc % 4] = empty_slot();

        reset = rst;
        if (arm_rst30 && s.strb[0] && s.addr == 8'h30) begin
            reset = 1'b1;
            arm_rst30 = 1'b0;
        end
        if (gnt_a) req_a = 1'b0;
        if (gnt_b) req_b = 1'b0;
        if (reset) begin
            req_a = 1'b0;
            req_b = 1'b0;
        end else begin
            if (!req_a && q_a.size() > 0 && cyc >= q_a[0].min_cyc) begin
                t = q_a.pop_front();
                req_a = 1'b1; we_a = t.we; addr_a = t.addr; wdata_a = t.wdata;
            end
            if (!req_b && q_b.size() > 0 && cyc >= q_b[0].min_cyc) begin
                t = q_b.pop_front();
                req_b = 1'b1; we_b = t.we; addr_b = t.addr; wdata_b = t.wdata;
            end
            if (cyc >= next_decide) decide();
        end
    endtask

    task automatic push(input logic port_b, input logic we, input logic [7:0] ad,
                        input logic [15:0] wd, input int min_cyc);
        txn_t t;
        t.we = we; t.addr = ad; t.wdata = wd; t.min_cyc = min_cyc;
        if (port_b) q_b.push_back(t);
        else q_a.push_back(t);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0 || req_a || req_b || cyc < next_decide)
               && n < max_cycles) begin
            cycle(1'b0);
            n++;
        end
        check("drain_timeout", {31'b0, n >= max_cycles}, 32'd0);
    endtask

    initial begin
        int ta, tb_c, g0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_mem[16] = 16'h1234;
        model_reset();

        // Reset held three cycles with no requests.
        for (int i = 0; i < 3; i++) cycle(1'b1);
        cycle(1'b0);
        check("reset_rdata_a", rdata_a, 16'h0000);
        check("reset_rdata_b", rdata_b, 16'h0000);

        // Single read of the preloaded word, then write/read-back on B.
        push(1'b0, 1'b0, 8'h10, 16'h0000, 0);
        drain(50);
        check("rdata_a_hold_0x10", rdata_a, 16'h1234);
        push(1'b1, 1'b1, 8'h20, 16'hBEEF, 0);
        push(1'b1, 1'b0, 8'h20, 16'h0000, 0);
        drain(50);
        check("rdata_b_readback_0x20", rdata_b, 16'hBEEF);

        // Both ports requesting continuously straight out of reset.
        cycle(1'b1);
        gnt_cyc.delete(); gnt_port.delete();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b0, 8'h10, 16'h0, 0);
            push(1'b1, 1'b0, 8'h20, 16'h0, 0);
        end
        drain(100);
        check("alt_grant_count", gnt_cyc.size(), 8);
        for (int i = 0; i < gnt_cyc.size() && i < 8; i++) begin
            check("alt_grant_port", {31'b0, gnt_port[i]}, i % 2);
            if (i > 0) check("alt_grant_spacing", gnt_cyc[i] - gnt_cyc[i-1], 3);
        end

        // A streams back-to-back; B joins mid-stream.
        gnt_cyc.delete(); gnt_port.delete();
        for (int i = 0; i < 6; i++) push(1'b0, 1'b1, 8'h40 + 8'(i), 16'hA000 + 16'(i), 0);
        push(1'b1, 1'b0, 8'h41, 16'h0, cyc + 5);
        g0 = cyc;
        drain(100);
        check("midstream_b_granted", {31'b0, gnt_port.size() == 7}, 1);

        // Reset lands during the ACCESS cycle of a write to 0x30.
        arm_rst30 = 1'b1;
        push(1'b1, 1'b1, 8'h30, 16'h5555, 0);
        drain(50);
        check("rst_write_consumed", {31'b0, arm_rst30}, 0);
        check("mem_0x30_after_reset", mem[8'h30], 16'h5555);
        push(1'b0, 1'b0, 8'h30, 16'h0, 0);
        drain(50);

        // Randomized traffic from both ports, including the 0x00/0xFF boundary words.
        ta = cyc; tb_c = cyc;
        for (int i = 0; i < 150; i++) begin
            ta   += $urandom_range(0, 6);
            tb_c += $urandom_range(0, 6);
            push(1'b0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                 16'($urandom), ta);
            push(1'b1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 15)),
                 16'($urandom), tb_c);
        end
        drain(5000);
        check("mem_0xff_final", mem[8'hFF], ref_mem[8'hFF]);
        check("mem_0x00_final", mem[8'h00], ref_mem[8'h00]);
        if (g0 < 0) $display("unreachable");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
